// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-op sequencer: fetches an opcode byte, maps it through the
// main/CB opcode LUTs and walks the micro-op ROM until an end-of-flow code,
// turning each ROM flow field into single-cycle datapath control pulses.
module dzcpu_uop_sequencer #(
    parameter int UPC_W  = 8,
    parameter int MOP_W  = 8,
    parameter int FLOW_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [MOP_W-1:0]  iMemData,
    input  logic              iMemReady,
    input  logic [UPC_W-1:0]  iLutIdx,
    input  logic [UPC_W-1:0]  iCbLutIdx,
    input  logic [FLOW_W-1:0] iFlow,
    input  logic              iZ,
    input  logic              iStall,
    output logic              oFetchReq,
    output logic [MOP_W-1:0]  oMop,
    output logic [MOP_W-1:0]  oCbMop,
    output logic [UPC_W-1:0]  oUopAddr,
    output logic              oUopValid,
    output logic              oPcInc,
    output logic              oFlagUpdate,
    output logic              oEof,
    output logic              oIllegal,
    output logic [CNT_W-1:0]  oInstrCount
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_CBMAP
    } state_t;

    localparam logic [FLOW_W-1:0] FL_OP         = FLOW_W'(0);
    localparam logic [FLOW_W-1:0] FL_INC        = FLOW_W'(1);
    localparam logic [FLOW_W-1:0] FL_EOF        = FLOW_W'(2);
    localparam logic [FLOW_W-1:0] FL_INC_EOF    = FLOW_W'(3);
    localparam logic [FLOW_W-1:0] FL_EOF_FU     = FLOW_W'(4);
    localparam logic [FLOW_W-1:0] FL_INC_EOF_FU = FLOW_W'(5);
    localparam logic [FLOW_W-1:0] FL_INC_EOF_Z  = FLOW_W'(6);
    localparam logic [FLOW_W-1:0] FL_INC_EOF_NZ = FLOW_W'(7);
    localparam logic [FLOW_W-1:0] FL_JCB        = FLOW_W'(8);

    state_t             state_q, state_d;
    logic [UPC_W-1:0]   upc_q, upc_d;
    logic [MOP_W-1:0]   mop_q, mop_d;
    logic [MOP_W-1:0]   cb_mop_q, cb_mop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic pc_inc, flag_update, eof, illegal;
    logic retire, advance;

    // Next-state, micro-PC stepping and flow-field decode into control pulses.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        upc_d       = upc_q;
        mop_d       = mop_q;
        cb_mop_d    = cb_mop_q;
        cnt_d       = cnt_q;
        pc_inc      = 1'b0;
        flag_update = 1'b0;
        eof         = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                if (iMemReady) begin
                    mop_d   = iMemData;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                upc_d   = iLutIdx;
                state_d = ST_EXEC;
            end

            ST_CBMAP: begin
                upc_d   = iCbLutIdx;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                if (!iStall) begin
                    case (iFlow)
                        FL_OP:         advance = 1'b1;
                        FL_INC:        begin pc_inc = 1'b1; advance = 1'b1; end
                        FL_EOF:        retire = 1'b1;
                        FL_INC_EOF:    begin pc_inc = 1'b1; retire = 1'b1; end
                        FL_EOF_FU:     begin flag_update = 1'b1; retire = 1'b1; end
                        FL_INC_EOF_FU: begin pc_inc = 1'b1; flag_update = 1'b1; retire = 1'b1; end
                        FL_INC_EOF_Z:  begin pc_inc = 1'b1; retire = iZ;  advance = !iZ; end
                        FL_INC_EOF_NZ: begin pc_inc = 1'b1; retire = !iZ; advance = iZ;  end
                        FL_JCB: begin
                            pc_inc   = 1'b1;
                            cb_mop_d = iMemData;
                            state_d  = ST_CBMAP;
                        end
                        default:       begin illegal = 1'b1; retire = 1'b1; end
                    endcase

                    // A flow that would step past the last ROM word is treated as illegal
                    // and retired rather than wrapping back to uPC 0.
                    if (advance && (&upc_q)) begin
                        advance = 1'b0;
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end

                    if (advance) begin
                        upc_d = upc_q + UPC_W'(1);
                    end
                    if (retire) begin
                        eof     = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, micro-PC, latched opcodes and retire counter; reset abandons any flow in progress.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= ST_IDLE;
            upc_q    <= '0;
            mop_q    <= '0;
            cb_mop_q <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            upc_q    <= upc_d;
            mop_q    <= mop_d;
            cb_mop_q <= cb_mop_d;
            cnt_q    <= cnt_d;
        end
    end

    assign oFetchReq   = (state_q == ST_FETCH);
    assign oUopValid   = (state_q == ST_EXEC) && !iStall;
    assign oUopAddr    = upc_q;
    assign oMop        = mop_q;
    assign oCbMop      = cb_mop_q;
    assign oInstrCount = cnt_q;
    assign oPcInc      = pc_inc;
    assign oFlagUpdate = flag_update;
    assign oEof        = eof;
    assign oIllegal    = illegal;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed, table-driven bench for dzcpu_uop_sequencer. Each table row is one
// clock cycle: the inputs to drive and the outputs expected mid-cycle.
module tb_dzcpu_uop_sequencer;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [7:0]  iMemData;
    logic        iMemReady;
    logic [7:0]  iLutIdx;
    logic [7:0]  iCbLutIdx;
    logic [3:0]  iFlow;
    logic        iZ;
    logic        iStall;

    logic        oFetchReq, oUopValid, oPcInc, oFlagUpdate, oEof, oIllegal;
    logic [7:0]  oMop, oCbMop, oUopAddr;
    logic [15:0] oInstrCount;

    // Second instance with a narrow counter so the wrap to 0 is reachable quickly.
    logic        s_fetch, s_valid, s_inc, s_fu, s_eof, s_ill;
    logic [7:0]  s_mop, s_cb, s_addr;
    logic [3:0]  s_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 iClock = ~iClock;

    dzcpu_uop_sequencer dut (
        .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iMemReady(iMemReady),
        .iLutIdx(iLutIdx), .iCbLutIdx(iCbLutIdx), .iFlow(iFlow), .iZ(iZ), .iStall(iStall),
        .oFetchReq(oFetchReq), .oMop(oMop), .oCbMop(oCbMop), .oUopAddr(oUopAddr),
        .oUopValid(oUopValid), .oPcInc(oPcInc), .oFlagUpdate(oFlagUpdate), .oEof(oEof),
        .oIllegal(oIllegal), .oInstrCount(oInstrCount)
    );

    dzcpu_uop_sequencer #(.CNT_W(4)) dut_small (
        .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iMemReady(iMemReady),
        .iLutIdx(iLutIdx), .iCbLutIdx(iCbLutIdx), .iFlow(iFlow), .iZ(iZ), .iStall(iStall),
        .oFetchReq(s_fetch), .oMop(s_mop), .oCbMop(s_cb), .oUopAddr(s_addr),
        .oUopValid(s_valid), .oPcInc(s_inc), .oFlagUpdate(s_fu), .oEof(s_eof),
        .oIllegal(s_ill), .oInstrCount(s_cnt)
    );

    typedef struct packed {
        logic [7:0]  mem;
        logic        rdy;
        logic [7:0]  lut;
        logic [7:0]  cblut;
        logic [3:0]  flow;
        logic        z;
        logic        stall;
        logic        fetch;
        logic        valid;
        logic [7:0]  addr;
        logic        inc;
        logic        fu;
        logic        eof;
        logic        ill;
        logic [7:0]  mop;
        logic [7:0]  cb;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [7:0] mem, input logic rdy, input logic [7:0] lut, input logic [7:0] cblut,
        input logic [3:0] flow, input logic z, input logic stall,
        input logic fetch, input logic valid, input logic [7:0] addr,
        input logic inc, input logic fu, input logic eof, input logic ill,
        input logic [7:0] mop, input logic [7:0] cb, input logic [15:0] cnt);
        vec_t v;
        v.mem = mem; v.rdy = rdy; v.lut = lut; v.cblut = cblut; v.flow = flow;
        v.z = z; v.stall = stall; v.fetch = fetch; v.valid = valid; v.addr = addr;
        v.inc = inc; v.fu = fu; v.eof = eof; v.ill = ill; v.mop = mop; v.cb = cb; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic logic [45:0] pack_out();
        return {oFetchReq, oUopValid, oUopAddr, oPcInc, oFlagUpdate, oEof, oIllegal,
                oMop, oCbMop, oInstrCount};
    endfunction

    initial begin
        // Row fields: mem rdy lut cblut flow z stall | fetch valid addr inc fu eof ill mop cb cnt
        // Single-step inc_eof instruction at uPC 0.
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,0, 0,0,8'h00,0,0,0,0, 8'h00,8'h00,16'd0)); // IDLE
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,0, 1,0,8'h00,0,0,0,0, 8'h00,8'h00,16'd0)); // FETCH
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,0, 0,0,8'h00,0,0,0,0, 8'h00,8'h00,16'd0)); // DECODE
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,0, 0,1,8'h00,1,0,1,0, 8'h00,8'h00,16'd0)); // EXEC 0
        // JRNZ flow, iZ=1: retire at uPC 19. First FETCH waits one cycle on iMemReady.
        vq.push_back(mk(8'h20,0,8'h00,8'h00,4'd0,0,0, 1,0,8'h00,0,0,0,0, 8'h00,8'h00,16'd1));
        vq.push_back(mk(8'h20,1,8'h00,8'h00,4'd0,0,0, 1,0,8'h00,0,0,0,0, 8'h00,8'h00,16'd1));
        vq.push_back(mk(8'h00,1,8'h11,8'h00,4'd0,0,0, 0,0,8'h00,0,0,0,0, 8'h20,8'h00,16'd1));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd1,0,0, 0,1,8'h11,1,0,0,0, 8'h20,8'h00,16'd1));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h12,0,0,0,0, 8'h20,8'h00,16'd1));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd6,1,0, 0,1,8'h13,1,0,1,0, 8'h20,8'h00,16'd1));
        // JRNZ flow, iZ=0: falls through to uPC 22.
        vq.push_back(mk(8'h20,1,8'h00,8'h00,4'd0,0,0, 1,0,8'h13,0,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h11,8'h00,4'd0,0,0, 0,0,8'h13,0,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd1,0,0, 0,1,8'h11,1,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h12,0,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd6,0,0, 0,1,8'h13,1,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h14,0,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h15,0,0,0,0, 8'h20,8'h00,16'd2));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd2,0,0, 0,1,8'h16,0,0,1,0, 8'h20,8'h00,16'd2));
        // CB prefix: jcb at uPC 15 latches 0x7C, CB LUT maps to uPC 16 (eof_fu).
        vq.push_back(mk(8'hCB,1,8'h00,8'h00,4'd0,0,0, 1,0,8'h16,0,0,0,0, 8'h20,8'h00,16'd3));
        vq.push_back(mk(8'h00,1,8'h0D,8'h00,4'd0,0,0, 0,0,8'h16,0,0,0,0, 8'hCB,8'h00,16'd3));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd1,0,0, 0,1,8'h0D,1,0,0,0, 8'hCB,8'h00,16'd3));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h0E,0,0,0,0, 8'hCB,8'h00,16'd3));
        vq.push_back(mk(8'h7C,1,8'h00,8'h00,4'd8,0,0, 0,1,8'h0F,1,0,0,0, 8'hCB,8'h00,16'd3));
        vq.push_back(mk(8'h00,1,8'h00,8'h10,4'd0,0,0, 0,0,8'h0F,0,0,0,0, 8'hCB,8'h7C,16'd3));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd4,0,0, 0,1,8'h10,0,1,1,0, 8'hCB,8'h7C,16'd3));
        // Stall: ignored in FETCH/DECODE, freezes uPC 2 for three EXEC cycles.
        vq.push_back(mk(8'h01,1,8'h00,8'h00,4'd0,0,1, 1,0,8'h10,0,0,0,0, 8'hCB,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h02,8'h00,4'd0,0,1, 0,0,8'h10,0,0,0,0, 8'h01,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,1, 0,0,8'h02,0,0,0,0, 8'h01,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,1, 0,0,8'h02,0,0,0,0, 8'h01,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,1, 0,0,8'h02,0,0,0,0, 8'h01,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h02,0,0,0,0, 8'h01,8'h7C,16'd4));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd3,0,0, 0,1,8'h03,1,0,1,0, 8'h01,8'h7C,16'd4));
        // Reserved flow code retires as illegal.
        vq.push_back(mk(8'hD3,1,8'h00,8'h00,4'd0,0,0, 1,0,8'h03,0,0,0,0, 8'h01,8'h7C,16'd5));
        vq.push_back(mk(8'h00,1,8'h05,8'h00,4'd0,0,0, 0,0,8'h03,0,0,0,0, 8'hD3,8'h7C,16'd5));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd15,0,0, 0,1,8'h05,0,0,1,1, 8'hD3,8'h7C,16'd5));
        // uPC overrun at 255 with a plain op: illegal retire, uPC stays 255.
        vq.push_back(mk(8'hD4,1,8'h00,8'h00,4'd0,0,0, 1,0,8'h05,0,0,0,0, 8'hD3,8'h7C,16'd6));
        vq.push_back(mk(8'h00,1,8'hFF,8'h00,4'd0,0,0, 0,0,8'h05,0,0,0,0, 8'hD4,8'h7C,16'd6));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'hFF,0,0,1,1, 8'hD4,8'h7C,16'd6));
        vq.push_back(mk(8'h10,1,8'h00,8'h00,4'd0,0,0, 1,0,8'hFF,0,0,0,0, 8'hD4,8'h7C,16'd7));
        // Walk into a flow that will be at uPC 40 when reset hits.
        vq.push_back(mk(8'h00,1,8'h27,8'h00,4'd0,0,0, 0,0,8'hFF,0,0,0,0, 8'h10,8'h7C,16'd7));
        vq.push_back(mk(8'h00,1,8'h00,8'h00,4'd0,0,0, 0,1,8'h27,0,0,0,0, 8'h10,8'h7C,16'd7));

        iReset = 1'b0; iMemData = '0; iMemReady = 1'b1; iLutIdx = '0; iCbLutIdx = '0;
        iFlow = '0; iZ = 1'b0; iStall = 1'b0;
        step();
        check("reset_state", 64'(pack_out()), 64'd0);
        iReset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            iMemData = v.mem; iMemReady = v.rdy; iLutIdx = v.lut; iCbLutIdx = v.cblut;
            iFlow = v.flow; iZ = v.z; iStall = v.stall;
            #1;
            check($sformatf("vec%0d", i), 64'(pack_out()),
                  64'({v.fetch, v.valid, v.addr, v.inc, v.fu, v.eof, v.ill, v.mop, v.cb, v.cnt}));
            step();
        end

        // Mid-EXEC at uPC 40 with an inc flow: pulse present, then async reset clears everything.
        iMemData = 8'h00; iLutIdx = 8'h00; iCbLutIdx = 8'h00; iFlow = 4'd1; iZ = 1'b0; iStall = 1'b0;
        #1;
        check("exec_upc40", 64'({oUopValid, oUopAddr, oPcInc, oInstrCount}), 64'({1'b1, 8'd40, 1'b1, 16'd7}));
        iReset = 1'b0;
        #1;
        check("reset_mid_exec", 64'(pack_out()), 64'd0);
        check("reset_small_cnt", 64'(s_cnt), 64'd0);
        step();
        iReset = 1'b1;

        // Retire counter wrap: 16 single-step instructions on both instances.
        iFlow = 4'd3; iLutIdx = 8'h00; iMemReady = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            int cyc;
            cyc = 0;
            while (!oEof && cyc < 10) begin
                step();
                cyc++;
            end
            if (!oEof) begin
                tests_run++;
                tests_failed++;
                $display("FAIL eof_timeout: instruction %0d never retired", k);
            end
            step();
            check($sformatf("cnt_main_%0d", k), 64'(oInstrCount), 64'(k));
            check($sformatf("cnt_small_%0d", k), 64'(s_cnt), 64'(k % 16));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
